// File: rtl/uam_pkg.sv
// Shared DUART channel definitions: transmit FSM states, MR1 character-length
// encoding and helpers that turn that encoding into bit counts and data masks.
package uam_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_t;

  localparam logic [1:0] BPC_5 = 2'b00;
  localparam logic [1:0] BPC_6 = 2'b01;
  localparam logic [1:0] BPC_7 = 2'b10;
  localparam logic [1:0] BPC_8 = 2'b11;

  function automatic logic [3:0] data_bits(input logic [1:0] bpc);
    return 4'd5 + {2'b00, bpc};
  endfunction

  // Keeps only the active data bits so parity ignores the unused upper bits.
  function automatic logic [7:0] char_mask(input logic [1:0] bpc);
    logic [7:0] m;
    case (bpc)
      BPC_5:   m = 8'h1F;
      BPC_6:   m = 8'h3F;
      BPC_7:   m = 8'h7F;
      default: m = 8'hFF;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/tx_channel_if.sv
// CPU / mode-register / pin side of one DUART transmit channel.
// master = the surrounding logic (or bench), slave = tx_channel.
interface tx_channel_if;
  logic       BaudTick;
  logic       TxEnable;
  logic       TxWrite;
  logic [7:0] TxData;
  logic [1:0] BitsPerChar;
  logic       ParityEn;
  logic       ParityOdd;
  logic       StopBits2;
  logic       CTSEN;
  logic       TxRTSC;
  logic       CTSn;
  logic       TxD;
  logic       TxRDY;
  logic       TxEMT;
  logic       RtsNegate;

  modport master (
    output BaudTick, TxEnable, TxWrite, TxData, BitsPerChar, ParityEn,
           ParityOdd, StopBits2, CTSEN, TxRTSC, CTSn,
    input  TxD, TxRDY, TxEMT, RtsNegate
  );

  modport slave (
    input  BaudTick, TxEnable, TxWrite, TxData, BitsPerChar, ParityEn,
           ParityOdd, StopBits2, CTSEN, TxRTSC, CTSn,
    output TxD, TxRDY, TxEMT, RtsNegate
  );
endinterface

// File: rtl/baud_bit_timer.sv
// Divide-by-OVERSAMPLE tick counter: bit_done_o fires on the baud tick that
// completes one bit period. Shared by the transmitter and receiver.
module baud_bit_timer #(
  parameter int OVERSAMPLE = 16
) (
  input  logic clk,
  input  logic rst_i,
  input  logic tick_i,
  input  logic clear_i,
  output logic bit_done_o
);

  localparam int CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(OVERSAMPLE - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    // NOTE: assign the hold value first so every path drives cnt_d; a missing
    // else branch in always_comb would otherwise infer a latch.
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (tick_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end
  end

  assign bit_done_o = tick_i & (cnt_q == LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/tx_channel.sv
// DUART channel transmitter: one-deep THR feeding a start/data/parity/stop
// serialiser, with CTS start gating, TxRDY/TxEMT status and auto-RTS negate.
module tx_channel
  import uam_pkg::*;
#(
  parameter int OVERSAMPLE = 16
) (
  input logic         clk,
  input logic         MrReset,
  tx_channel_if.slave bus
);

  tx_state_t  state_q, state_d;
  logic [7:0] thr_q, thr_d;
  logic       thr_full_q, thr_full_d;
  logic [7:0] shift_q, shift_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic       stop_cnt_q, stop_cnt_d;
  logic       parity_q, parity_d;
  logic [1:0] bpc_q, bpc_d;
  logic       par_en_q, par_en_d;
  logic       stop2_q, stop2_d;
  logic       txd_q, txd_d;
  logic       txrdy_q, txrdy_d;
  logic       txemt_q, txemt_d;
  logic       rts_q, rts_d;

  logic       bit_done;
  logic       timer_clear;
  logic       start_ok;
  logic       transfer;
  logic [7:0] char_next;
  logic [3:0] last_bit;

  // Counter sits at zero while idle, so every frame starts on a fresh period.
  assign timer_clear = (state_q == IDLE);

  baud_bit_timer #(.OVERSAMPLE(OVERSAMPLE)) u_timer (
    .clk        (clk),
    .rst_i      (MrReset),
    .tick_i     (bus.BaudTick),
    .clear_i    (timer_clear),
    .bit_done_o (bit_done)
  );

  // THR only fills while enabled, so a full THR is always eligible to send,
  // including the character left behind when TxEnable drops.
  assign start_ok  = thr_full_q & (~bus.CTSEN | ~bus.CTSn);
  assign char_next = thr_q & char_mask(bus.BitsPerChar);
  assign last_bit  = data_bits(bpc_q) - 4'd1;

  always_comb begin
    state_d    = state_q;
    thr_d      = thr_q;
    thr_full_d = thr_full_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    stop_cnt_d = stop_cnt_q;
    parity_d   = parity_q;
    bpc_d      = bpc_q;
    par_en_d   = par_en_q;
    stop2_d    = stop2_q;
    rts_d      = 1'b0;
    transfer   = 1'b0;

    case (state_q)
      IDLE: transfer = start_ok;
      START: if (bit_done) state_d = DATA;
      DATA: begin
        if (bit_done) begin
          shift_d = shift_q >> 1;
          if ({1'b0, bit_cnt_q} == last_bit) begin
            state_d    = par_en_q ? PARITY : STOP;
            stop_cnt_d = 1'b0;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (bit_done) begin
          state_d    = STOP;
          stop_cnt_d = 1'b0;
        end
      end
      STOP: begin
        if (bit_done) begin
          if (!stop2_q || stop_cnt_q) begin
            if (start_ok) begin
              transfer = 1'b1;
            end else begin
              state_d = IDLE;
              rts_d   = bus.TxRTSC & ~thr_full_q;
            end
          end else begin
            stop_cnt_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Format is frozen here for the whole character.
    if (transfer) begin
      state_d    = START;
      shift_d    = char_next;
      parity_d   = (^char_next) ^ bus.ParityOdd;
      bpc_d      = bus.BitsPerChar;
      par_en_d   = bus.ParityEn;
      stop2_d    = bus.StopBits2;
      bit_cnt_d  = 3'd0;
      thr_full_d = 1'b0;
    end

    if (bus.TxWrite && bus.TxEnable && (!thr_full_q || transfer)) begin
      thr_d      = bus.TxData;
      thr_full_d = 1'b1;
    end

    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      PARITY:  txd_d = parity_d;
      default: txd_d = 1'b1;
    endcase

    txrdy_d = bus.TxEnable & ~thr_full_d;
    txemt_d = ~thr_full_d & (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (MrReset) begin
      state_q    <= IDLE;
      thr_q      <= '0;
      thr_full_q <= 1'b0;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      stop_cnt_q <= 1'b0;
      parity_q   <= 1'b0;
      bpc_q      <= '0;
      par_en_q   <= 1'b0;
      stop2_q    <= 1'b0;
      txd_q      <= 1'b1;
      txrdy_q    <= 1'b0;
      txemt_q    <= 1'b1;
      rts_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      thr_q      <= thr_d;
      thr_full_q <= thr_full_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      stop_cnt_q <= stop_cnt_d;
      parity_q   <= parity_d;
      bpc_q      <= bpc_d;
      par_en_q   <= par_en_d;
      stop2_q    <= stop2_d;
      txd_q      <= txd_d;
      txrdy_q    <= txrdy_d;
      txemt_q    <= txemt_d;
      rts_q      <= rts_d;
    end
  end

  assign bus.TxD       = txd_q;
  assign bus.TxRDY     = txrdy_q;
  assign bus.TxEMT     = txemt_q;
  assign bus.RtsNegate = rts_q;

endmodule

// File: tb/tb_tx_channel.sv
// Bench for tx_channel: a tick-counting line monitor decodes TxD frames and
// compares them against expected frames queued when each byte is written.
module tb_tx_channel;
  import uam_pkg::*;

  logic clk = 1'b0;
  logic MrReset;

  tx_channel_if bus ();

  tx_channel #(.OVERSAMPLE(16)) dut (
    .clk     (clk),
    .MrReset (MrReset),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic [1:0]  bpc;
    logic        par_en;
    logic        par_odd;
    logic        stop2;
    logic [11:0] exp_bits;
    int          exp_n;
  } vec_t;

  typedef struct {
    logic [11:0] bits;
    int          n;
  } frame_t;

  frame_t sb[$];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Baud tick every second clock; tick_en lets a test freeze the bit timing.
  logic tick_en = 1'b1;
  int   tdiv = 0;
  logic tick_seen = 1'b0;
  logic rst_seen = 1'b1;

  always @(negedge clk) begin
    tdiv++;
    bus.BaudTick = tick_en & tdiv[0];
  end

  always @(posedge clk) begin
    tick_seen <= bus.BaudTick;
    rst_seen  <= MrReset;
  end

  // Line monitor: bit index = ticks consumed since the start edge / 16.
  logic        in_frame = 1'b0;
  logic        stable;
  logic [11:0] got;
  frame_t      cur;
  int          tc, nrec, cur_idx = 0;
  int          frames_started = 0, frames_done = 0;
  int          idle_clks = 0, last_gap = -1, rts_cnt = 0;
  logic        rts_at_end = 1'b0;

  task automatic begin_frame();
    frames_started++;
    last_gap = idle_clks;
    in_frame = 1'b1;
    tc       = 0;
    cur_idx  = 0;
    nrec     = 1;
    got      = '1;
    got[0]   = bus.TxD;
    stable   = 1'b1;
    check("frame_expected", 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) cur = sb.pop_front();
    else begin
      cur.bits = 12'hFFF;
      cur.n    = 10;
    end
  endtask

  always @(negedge clk) begin
    logic [11:0] m;
    if (bus.RtsNegate === 1'b1) rts_cnt++;
    if (rst_seen) begin
      in_frame  = 1'b0;
      idle_clks = 0;
    end else if (!in_frame) begin
      if (bus.TxD === 1'b0) begin_frame();
      else idle_clks++;
    end else begin
      tc += int'(tick_seen);
      cur_idx = tc / 16;
      if (cur_idx >= cur.n) begin
        m = 12'((1 << cur.n) - 1);
        check("frame_bits", 32'(got & m), 32'(cur.bits));
        check("frame_stable", 32'(stable), 32'd1);
        frames_done++;
        rts_at_end = bus.RtsNegate;
        in_frame   = 1'b0;
        idle_clks  = 0;
        if (bus.TxD === 1'b0) begin_frame();
      end else if (cur_idx == nrec) begin
        got[cur_idx] = bus.TxD;
        nrec++;
      end else if (got[cur_idx] !== bus.TxD) begin
        stable = 1'b0;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_byte(input logic [7:0] b);
    @(negedge clk);
    bus.TxData  = b;
    bus.TxWrite = 1'b1;
    @(negedge clk);
    bus.TxWrite = 1'b0;
  endtask

  task automatic set_fmt(input logic [1:0] bpc, input logic pe, input logic po, input logic s2);
    bus.BitsPerChar = bpc;
    bus.ParityEn    = pe;
    bus.ParityOdd   = po;
    bus.StopBits2   = s2;
  endtask

  task automatic push(input logic [11:0] bits, input int n);
    frame_t f;
    f.bits = bits;
    f.n    = n;
    sb.push_back(f);
  endtask

  task automatic wait_done(input int target, input string name);
    int k = 0;
    while (frames_done < target && k < 3000) begin
      @(negedge clk);
      k++;
    end
    check(name, 32'(frames_done >= target), 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    int   prev, r0, s0, k;
    logic ok;

    vecs[0] = '{8'h55, BPC_8, 1'b0, 1'b0, 1'b0, 12'h2AA, 10};
    vecs[1] = '{8'h03, BPC_7, 1'b1, 1'b0, 1'b1, 12'h606, 11};
    vecs[2] = '{8'h03, BPC_7, 1'b1, 1'b1, 1'b1, 12'h706, 11};
    vecs[3] = '{8'hFE, BPC_5, 1'b1, 1'b0, 1'b1, 12'h1BC, 9};
    vecs[4] = '{8'hFF, BPC_6, 1'b1, 1'b1, 1'b0, 12'h1FE, 9};
    vecs[5] = '{8'h81, BPC_5, 1'b0, 1'b0, 1'b0, 12'h042, 7};

    MrReset      = 1'b1;
    bus.TxEnable = 1'b0;
    bus.TxWrite  = 1'b0;
    bus.TxData   = 8'h00;
    bus.CTSEN    = 1'b0;
    bus.TxRTSC   = 1'b0;
    bus.CTSn     = 1'b1;
    set_fmt(BPC_8, 1'b0, 1'b0, 1'b0);
    idle(4);
    check("rst_txd", 32'(bus.TxD), 32'd1);
    check("rst_txrdy", 32'(bus.TxRDY), 32'd0);
    check("rst_txemt", 32'(bus.TxEMT), 32'd1);
    check("rst_rtsneg", 32'(bus.RtsNegate), 32'd0);
    MrReset = 1'b0;
    idle(2);
    check("txrdy_disabled", 32'(bus.TxRDY), 32'd0);
    bus.TxEnable = 1'b1;
    idle(1);
    check("txrdy_enabled", 32'(bus.TxRDY), 32'd1);

    // Table-driven single frames; format inputs are scrambled mid-frame.
    for (int i = 0; i < 6; i++) begin
      set_fmt(vecs[i].bpc, vecs[i].par_en, vecs[i].par_odd, vecs[i].stop2);
      push(vecs[i].exp_bits, vecs[i].exp_n);
      prev = frames_done;
      write_byte(vecs[i].data);
      if (i == 0) begin
        check("thr_full_txd", 32'(bus.TxD), 32'd1);
        check("thr_full_txrdy", 32'(bus.TxRDY), 32'd0);
        check("thr_full_txemt", 32'(bus.TxEMT), 32'd0);
        idle(1);
        check("xfer_txd", 32'(bus.TxD), 32'd0);
        check("xfer_txrdy", 32'(bus.TxRDY), 32'd1);
        check("xfer_txemt", 32'(bus.TxEMT), 32'd0);
      end
      idle(2);
      set_fmt(~vecs[i].bpc, ~vecs[i].par_en, ~vecs[i].par_odd, ~vecs[i].stop2);
      if (i == 0) begin
        idle(60);
        tick_en = 1'b0;
        idle(40);
        tick_en = 1'b1;
      end
      wait_done(prev + 1, "frame_done");
      idle(2);
      check("end_txemt", 32'(bus.TxEMT), 32'd1);
      check("end_txrdy", 32'(bus.TxRDY), 32'd1);
    end
    set_fmt(BPC_8, 1'b0, 1'b0, 1'b0);

    // Writes while disabled are dropped.
    bus.TxEnable = 1'b0;
    s0 = frames_started;
    write_byte(8'h12);
    idle(100);
    check("dis_write_txemt", 32'(bus.TxEMT), 32'd1);
    check("dis_write_noframe", 32'(frames_started), 32'(s0));
    check("dis_write_txrdy", 32'(bus.TxRDY), 32'd0);
    bus.TxEnable = 1'b1;
    idle(2);

    // Back-to-back: second write accepted while shifting, third ignored.
    prev = frames_done;
    push(12'h34A, 10);
    push(12'h278, 10);
    write_byte(8'hA5);
    idle(30);
    write_byte(8'h3C);
    check("b2b_txrdy_full", 32'(bus.TxRDY), 32'd0);
    write_byte(8'h77);
    wait_done(prev + 2, "b2b_done");
    check("b2b_gap", 32'(last_gap), 32'd0);
    idle(2);
    check("b2b_txemt", 32'(bus.TxEMT), 32'd1);

    // TxEnable drops mid-frame with a character queued: both still go out.
    prev = frames_done;
    push(12'h2AA, 10);
    push(12'h21E, 10);
    write_byte(8'h55);
    idle(20);
    write_byte(8'h0F);
    idle(5);
    bus.TxEnable = 1'b0;
    write_byte(8'h77);
    wait_done(prev + 2, "drain_done");
    idle(2);
    check("drain_txemt", 32'(bus.TxEMT), 32'd1);
    check("drain_txrdy", 32'(bus.TxRDY), 32'd0);
    bus.TxEnable = 1'b1;
    idle(2);

    // CTS gating at character start only.
    bus.CTSEN = 1'b1;
    bus.CTSn  = 1'b1;
    prev = frames_done;
    push(12'h302, 10);
    write_byte(8'h81);
    ok = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (bus.TxD !== 1'b1) ok = 1'b0;
    end
    check("cts_hold_txd", 32'(ok), 32'd1);
    check("cts_hold_txemt", 32'(bus.TxEMT), 32'd0);
    bus.CTSn = 1'b0;
    k = 0;
    while (bus.TxD !== 1'b0 && k < 2) begin
      @(negedge clk);
      k++;
    end
    check("cts_start", 32'(bus.TxD), 32'd0);
    idle(100);
    bus.CTSn = 1'b1;
    wait_done(prev + 1, "cts_done");
    bus.CTSEN = 1'b0;
    idle(2);

    // Auto RTS negate: one pulse at the end of the last stop bit.
    bus.TxRTSC = 1'b1;
    r0 = rts_cnt;
    prev = frames_done;
    push(12'h2AA, 10);
    write_byte(8'h55);
    wait_done(prev + 1, "rts1_done");
    idle(3);
    check("rts1_count", 32'(rts_cnt - r0), 32'd1);
    check("rts1_at_end", 32'(rts_at_end), 32'd1);
    r0 = rts_cnt;
    prev = frames_done;
    push(12'h34A, 10);
    push(12'h278, 10);
    write_byte(8'hA5);
    idle(30);
    write_byte(8'h3C);
    wait_done(prev + 2, "rts2_done");
    idle(3);
    check("rts2_count", 32'(rts_cnt - r0), 32'd1);
    check("rts2_at_end", 32'(rts_at_end), 32'd1);

    // Reset during data bit 3 of 0xFF, colliding with a write.
    r0 = rts_cnt;
    push(12'h3FE, 10);
    write_byte(8'hFF);
    k = 0;
    while (!(in_frame && cur_idx == 4) && k < 1000) begin
      @(negedge clk);
      k++;
    end
    check("rst_reach_data3", 32'(in_frame && cur_idx == 4), 32'd1);
    MrReset     = 1'b1;
    bus.TxData  = 8'h99;
    bus.TxWrite = 1'b1;
    @(negedge clk);
    check("midrst_txd", 32'(bus.TxD), 32'd1);
    check("midrst_txemt", 32'(bus.TxEMT), 32'd1);
    check("midrst_txrdy", 32'(bus.TxRDY), 32'd0);
    check("midrst_rtsneg", 32'(bus.RtsNegate), 32'd0);
    MrReset     = 1'b0;
    bus.TxWrite = 1'b0;
    s0 = frames_started;
    idle(100);
    check("postrst_noframe", 32'(frames_started), 32'(s0));
    check("postrst_txemt", 32'(bus.TxEMT), 32'd1);
    check("postrst_txrdy", 32'(bus.TxRDY), 32'd1);
    check("postrst_no_rts", 32'(rts_cnt), 32'(r0));
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
